// File: rtl/conv_window_fetch.sv
// conv_window_fetch: fetches 3x3 pixel windows from an image SRAM in row-major centre order.
// Define CONV_ZERO_PAD_EN to visit every pixel as a centre, with out-of-image taps read as zero.
package conv_window_fetch_pkg;
    parameter int SRAM_AW = 16;
    typedef struct packed {
        logic               en;
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [7:0]         wdata;
    } img_sram_ctrl_t;
endpackage

module conv_window_fetch
    import conv_window_fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [7:0]     nrows,
    input  logic [7:0]     ncols,
    output logic           busy,
    output img_sram_ctrl_t sram_ctrl,
    input  logic [7:0]     sram_dout_in,
    output logic           win_valid,
    input  logic           win_ready,
    output logic [71:0]    win_pix,
    output logic [7:0]     win_row,
    output logic [7:0]     win_col
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
    state_t state, state_d;
    logic [7:0] nrows_q, ncols_q, r, c, row_last, col_last;
    logic [3:0] k, cap_idx;
    logic cap_pend, cap_zero, empty, oob, last, reading;
    logic [15:0] dr, dc, rr, cc;
    logic [8:0][7:0] taps;

`ifdef CONV_ZERO_PAD_EN
    localparam logic [7:0] ORG = 8'd0;
    localparam logic [7:0] MARGIN = 8'd1;
    assign empty = (nrows == 8'd0) || (ncols == 8'd0);
    // r-1 / c-1 wrap to 0xFFFF at the top/left border, so one unsigned compare covers both sides
    assign oob = (rr >= {8'd0, nrows_q}) || (cc >= {8'd0, ncols_q});
`else
    localparam logic [7:0] ORG = 8'd1;
    localparam logic [7:0] MARGIN = 8'd2;
    assign empty = (nrows < 8'd3) || (ncols < 8'd3);
    assign oob = 1'b0;
`endif

    assign dr = (k >= 4'd6) ? 16'd2 : (k >= 4'd3) ? 16'd1 : 16'd0;
    assign dc = {12'd0, k} - 16'd3 * dr;
    assign rr = {8'd0, r} + dr - 16'd1;
    assign cc = {8'd0, c} + dc - 16'd1;
    assign row_last = nrows_q - MARGIN;
    assign col_last = ncols_q - MARGIN;
    assign last = (r == row_last) && (c == col_last);
    assign reading = (state == FETCH) && (k < 4'd9);
    assign sram_ctrl = '{en: reading && !oob, we: 1'b0,
                         addr: SRAM_AW'(rr * {8'd0, ncols_q} + cc), wdata: 8'd0};
    assign busy = (state != IDLE);
    assign win_pix = taps;
    assign win_row = r;
    assign win_col = c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = en ? (empty ? DONE : FETCH) : IDLE;
            FETCH:   state_d = (k == 4'd9) ? HOLD : FETCH;
            HOLD:    state_d = win_ready ? (last ? DONE : FETCH) : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // k runs 0..9: reads on 0..8, the extra cycle lands the tap-8 data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nrows_q   <= 8'd0;
            ncols_q   <= 8'd0;
            r         <= 8'd0;
            c         <= 8'd0;
            k         <= 4'd0;
            cap_idx   <= 4'd0;
            cap_pend  <= 1'b0;
            cap_zero  <= 1'b0;
            taps      <= '0;
            win_valid <= 1'b0;
        end else begin
            cap_pend <= reading;
            cap_zero <= oob;
            cap_idx  <= k;
            if (cap_pend) taps[cap_idx] <= cap_zero ? 8'd0 : sram_dout_in;
            if (state == IDLE && en) begin
                nrows_q <= nrows;
                ncols_q <= ncols;
                r       <= ORG;
                c       <= ORG;
                k       <= 4'd0;
            end
            if (state == FETCH) k <= k + 4'd1;
            if (state == FETCH && k == 4'd9) win_valid <= 1'b1;
            if (state == HOLD && win_ready) begin
                win_valid <= 1'b0;
                k         <= 4'd0;
                r         <= (c == col_last) ? r + 8'd1 : r;
                c         <= (c == col_last) ? ORG : c + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_fetch.sv
// tb_conv_window_fetch: random-image bench with a queue of expected windows built by direct 3x3 extraction.
module tb_conv_window_fetch;
    import conv_window_fetch_pkg::*;

    logic clk = 1'b0, rstn = 1'b0, en = 1'b0, win_ready = 1'b0;
    logic [7:0] nrows = 8'd0, ncols = 8'd0, sram_dout_in = 8'd0;
    logic busy, win_valid;
    img_sram_ctrl_t sram_ctrl;
    logic [71:0] win_pix;
    logic [7:0] win_row, win_col;

    typedef struct {
        logic [71:0] pix;
        logic [7:0]  row;
        logic [7:0]  col;
    } win_t;
    win_t exp_q[$];
    logic [7:0] mem [65536];
    int n_chk = 0, n_fail = 0, reads = 0, cyc = 0, en_cyc = 0, first_cyc = 0;
    int stall_len = 0, vcnt = 0, npop = 0;
    bit checking = 1'b0, rnd_ready = 1'b0, got_first = 1'b0;

    always #5 clk = ~clk;

    conv_window_fetch dut (
        .clk(clk), .rstn(rstn), .en(en), .nrows(nrows), .ncols(ncols), .busy(busy),
        .sram_ctrl(sram_ctrl), .sram_dout_in(sram_dout_in), .win_valid(win_valid),
        .win_ready(win_ready), .win_pix(win_pix), .win_row(win_row), .win_col(win_col)
    );

    // SRAM: data one cycle after the request, junk otherwise so late captures show up
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_ctrl.en) begin
            sram_dout_in <= mem[sram_ctrl.addr];
            reads <= reads + 1;
        end else sram_dout_in <= 8'($urandom);
    end

    task automatic chk(string name, logic [71:0] act, logic [71:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) if (checking) begin
        chk("sram_we", 72'(sram_ctrl.we), 72'(0));
        if (win_valid) begin
            chk("busy_in_hold", 72'(busy), 72'(1));
            chk("read_in_hold", 72'(sram_ctrl.en), 72'(0));
            if (!got_first) begin
                got_first = 1'b1;
                first_cyc = cyc;
            end
            if (exp_q.size() == 0) chk("extra_window", 72'(win_valid), 72'(0));
            else begin
                chk("win_pix", win_pix, exp_q[0].pix);
                chk("win_row", 72'(win_row), 72'(exp_q[0].row));
                chk("win_col", 72'(win_col), 72'(exp_q[0].col));
            end
            vcnt++;
            win_ready = (vcnt > stall_len) && (!rnd_ready || $urandom_range(0, 1) == 1);
            if (win_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                vcnt = 0;
                npop++;
            end
        end else win_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    task automatic fill(int nr, int nc, int mode);
        for (int y = 0; y < nr; y++)
            for (int x = 0; x < nc; x++)
                mem[y*nc+x] = (mode == 0) ? 8'(y*nc+x) : (mode == 2) ? 8'(y*nc+x+1) : 8'($urandom);
    endtask

    task automatic build_model(int nr, int nc, output int nrd);
        int lo, hr, hc;
        win_t w;
`ifdef CONV_ZERO_PAD_EN
        lo = 0; hr = nr - 1; hc = nc - 1;
`else
        lo = 1; hr = nr - 2; hc = nc - 2;
`endif
        exp_q.delete();
        nrd = 0;
        for (int y = lo; y <= hr; y++)
            for (int x = lo; x <= hc; x++) begin
                w.row = 8'(y);
                w.col = 8'(x);
                w.pix = '0;
                for (int t = 0; t < 9; t++) begin
                    int yy = y + t / 3 - 1;
                    int xx = x + t % 3 - 1;
                    if (yy >= 0 && yy < nr && xx >= 0 && xx < nc) begin
                        nrd++;
                        w.pix[8*t+:8] = mem[yy*nc+xx];
                    end
                end
                exp_q.push_back(w);
            end
    endtask

    task automatic run_job(int nr, int nc, int stall, bit rnd, bit do_reset, int nrd);
        int r0, budget;
        @(negedge clk);
        nrows = 8'(nr); ncols = 8'(nc); en = 1'b1;
        stall_len = stall; rnd_ready = rnd; vcnt = 0; npop = 0; got_first = 1'b0;
        r0 = reads; en_cyc = cyc; checking = 1'b1;
        @(negedge clk);
        en = 1'b0; nrows = 8'($urandom); ncols = 8'($urandom);
        if (exp_q.size() == 0) begin
            chk("empty_busy_first", 72'(busy), 72'(1));
            @(negedge clk);
            chk("empty_busy_after", 72'(busy), 72'(0));
            chk("empty_reads", 72'(reads - r0), 72'(0));
            checking = 1'b0;
            return;
        end
        if (do_reset) begin
            for (budget = 0; budget < 200 && npop < 1; budget++) begin
                @(negedge clk);
                #1;
            end
            chk("reset_first_pop", 72'(npop), 72'(1));
            repeat (5) @(negedge clk);
            checking = 1'b0;
            rstn = 1'b0;
            #2;
            chk("rst_busy", 72'(busy), 72'(0));
            chk("rst_valid", 72'(win_valid), 72'(0));
            chk("rst_read", 72'(sram_ctrl.en), 72'(0));
            chk("rst_pix", win_pix, 72'(0));
            chk("rst_row_col", 72'({win_row, win_col}), 72'(0));
            @(negedge clk);
            rstn = 1'b1;
            exp_q.delete();
            repeat (3) @(negedge clk);
            chk("no_resume_busy", 72'(busy), 72'(0));
            chk("no_resume_valid", 72'(win_valid), 72'(0));
            return;
        end
        budget = exp_q.size() * (40 + stall) + 100;
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
        chk("windows_left", 72'(exp_q.size()), 72'(0));
        for (int i = 0; i < 6 && busy; i++) @(negedge clk);
        chk("busy_drop", 72'(busy), 72'(0));
        chk("valid_idle", 72'(win_valid), 72'(0));
        chk("first_latency", 72'(first_cyc - en_cyc), 72'(11));
        chk("read_count", 72'(reads - r0), 72'(nrd));
        checking = 1'b0;
    endtask

    initial begin
        int nrd, nr, nc;
        repeat (3) @(negedge clk);
        chk("reset_busy", 72'(busy), 72'(0));
        chk("reset_valid", 72'(win_valid), 72'(0));
        chk("reset_read", 72'(sram_ctrl.en), 72'(0));
        chk("reset_pix", win_pix, 72'(0));
        rstn = 1'b1;
        fill(4, 4, 0);
        build_model(4, 4, nrd);
`ifndef CONV_ZERO_PAD_EN
        chk("model_windows", 72'(exp_q.size()), 72'(4));
        chk("model_first_pix", exp_q[0].pix, 72'h0a0908060504020100);
        chk("model_last_centre", 72'({exp_q[3].row, exp_q[3].col}), 72'h0202);
        chk("model_reads", 72'(nrd), 72'(36));
`endif
        run_job(4, 4, 0, 1'b0, 1'b0, nrd);
        build_model(4, 4, nrd);
        run_job(4, 4, 20, 1'b0, 1'b0, nrd);
        fill(2, 128, 1);
        build_model(2, 128, nrd);
        run_job(2, 128, 0, 1'b1, 1'b0, nrd);
        fill(4, 4, 0);
        build_model(4, 4, nrd);
        run_job(4, 4, 0, 1'b0, 1'b1, nrd);
        build_model(4, 4, nrd);
        run_job(4, 4, 0, 1'b1, 1'b0, nrd);
`ifdef CONV_ZERO_PAD_EN
        fill(3, 3, 2);
        build_model(3, 3, nrd);
        chk("pad_model_windows", 72'(exp_q.size()), 72'(9));
        chk("pad_model_first_pix", exp_q[0].pix, 72'h050400020100000000);
        chk("pad_model_reads", 72'(nrd), 72'(49));
        run_job(3, 3, 0, 1'b1, 1'b0, nrd);
`endif
        for (int j = 0; j < 6; j++) begin
            nr = $urandom_range(0, 9);
            nc = $urandom_range(0, 9);
            fill(nr, nc, 1);
            build_model(nr, nc, nrd);
            run_job(nr, nc, 0, 1'b1, 1'b0, nrd);
        end
        fill(4, 255, 1);
        build_model(4, 255, nrd);
        run_job(4, 255, 0, 1'b1, 1'b0, nrd);
        fill(40, 40, 1);
        build_model(40, 40, nrd);
        run_job(40, 40, 0, 1'b1, 1'b0, nrd);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
